// File: rtl/digit_entry_counter_pkg.sv
// digit_entry_pkg: shared types and helpers for digit_entry_counter.
//   debounce_cnt_w : width of a debounce counter able to hold DEBOUNCE_CYCLES.
//   step_digit     : one digit step (up/down, wrap or saturate) with carry out.
package digit_entry_pkg;

    // Digit values travel at a fixed 32-bit width so one function serves any DIGIT_W.
    typedef struct packed {
        logic [31:0] digit;
        logic        carry;
    } step_t;

    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // cin=1 requests a step: either the pressed digit itself or a rippled carry/borrow.
    // With wrap=0 the digit saturates and carry is never produced.
    function automatic step_t step_digit(input logic [31:0] d,
                                         input logic        down,
                                         input logic        cin,
                                         input logic        wrap,
                                         input int          radix);
        step_t r;
        r.digit = d;
        r.carry = 1'b0;
        if (cin) begin
            if (!down) begin
                if (d == 32'(radix - 1)) begin
                    if (wrap) begin
                        r.digit = '0;
                        r.carry = 1'b1;
                    end
                end else begin
                    r.digit = d + 32'd1;
                end
            end else begin
                if (d == 32'd0) begin
                    if (wrap) begin
                        r.digit = 32'(radix - 1);
                        r.carry = 1'b1;
                    end
                end else begin
                    r.digit = d - 32'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_entry_counter_if.sv
// digit_entry_counter_if: button/control inputs and number outputs.
//   btn      : raw push-buttons, btn[0] owns the most-significant digit
//   dir      : 0 = increment, 1 = decrement
//   carry_en : propagate carry/borrow to more-significant digits (wrap mode only)
//   clr      : synchronous clear to INIT
//   num      : packed digit value
//   changed  : one-cycle pulse after every update of num
//   busy     : at least one press pending
interface digit_entry_counter_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    logic [DIGITS-1:0]         btn;
    logic                      dir;
    logic                      carry_en;
    logic                      clr;
    logic [DIGITS*DIGIT_W-1:0] num;
    logic                      changed;
    logic                      busy;

    modport master (output btn, dir, carry_en, clr, input num, changed, busy);
    modport slave  (input btn, dir, carry_en, clr, output num, changed, busy);
endinterface

// File: rtl/digit_entry_counter_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debouncer and rising-edge detect for one button.
//   clk, rst_n : clock and asynchronous active-low reset
//   btn_i      : raw asynchronous button level
//   rise_o     : single-cycle pulse, high in the cycle the debounced level rises
module btn_debounce
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);
    localparam int             CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Rise is taken from the next level so pending sets on the same edge the level rises.
    assign rise_o = level_d & ~level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/digit_entry_counter.sv
// digit_entry_counter: push-button driven multi-digit number entry.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of digit_entry_counter_if (btn/dir/carry_en/clr in,
//                num/changed/busy out)
module digit_entry_counter
    import digit_entry_pkg::*;
#(
    parameter int                          DIGITS          = 4,
    parameter int                          DIGIT_W         = 4,
    parameter int                          RADIX           = 16,
    parameter logic [DIGITS*DIGIT_W-1:0]   INIT            = 16'hABCD,
    parameter int                          DEBOUNCE_CYCLES = 1_000_000,
    parameter int                          WRAP            = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_entry_counter_if.slave bus
);
    localparam int NUM_W = DIGITS * DIGIT_W;

    logic [DIGITS-1:0] rise;
    logic [DIGITS-1:0] pending_q, pending_d;
    logic [DIGITS-1:0] grant;
    logic [NUM_W-1:0]  num_q, num_d, stepped;
    logic              changed_q, changed_d;
    logic              busy_q, busy_d;
    logic              carry;
    logic [DIGIT_W:0]  res;

    // Narrow wrapper: returns {carry, digit} at DIGIT_W bits.
    function automatic logic [DIGIT_W:0] step_field(input logic [DIGIT_W-1:0] d,
                                                    input logic down,
                                                    input logic cin);
        step_t r;
        r = step_digit(32'(d), down, cin, WRAP != 0, RADIX);
        return {r.carry, r.digit[DIGIT_W-1:0]};
    endfunction

    for (genvar i = 0; i < DIGITS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (bus.btn[i]),
            .rise_o(rise[i])
        );
    end

    // Lowest pending index wins: scanning downwards, the last hit is the lowest.
    always_comb begin
        grant = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    // Ripple from the highest index (least-significant digit) towards index 0.
    // Digits above the granted one see no step and produce no carry.
    always_comb begin
        stepped = num_q;
        carry   = 1'b0;
        res     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            res = step_field(num_q[(DIGITS-i)*DIGIT_W-1 -: DIGIT_W], bus.dir,
                             grant[i] | (carry & bus.carry_en));
            stepped[(DIGITS-i)*DIGIT_W-1 -: DIGIT_W] = res[DIGIT_W-1:0];
            carry = res[DIGIT_W];
        end
    end

    always_comb begin
        num_d     = num_q;
        pending_d = (pending_q & ~grant) | rise;
        changed_d = |grant;
        if (|grant) begin
            num_d = stepped;
        end
        if (bus.clr) begin
            num_d     = INIT;
            pending_d = '0;
            changed_d = 1'b1;
        end
        busy_d = |pending_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= INIT;
            pending_q <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            num_q     <= num_d;
            pending_q <= pending_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.num     = num_q;
    assign bus.changed = changed_q;
    assign bus.busy    = busy_q;
endmodule

// File: doc/digit_entry_counter.md
# digit_entry_counter

Parametrised, synchronously clocked button-driven multi-digit number entry. Each push-button steps one digit of a packed DIGITS-digit, radix-RADIX value up or down. Inputs are synchronised, debounced and edge-detected, with optional wrap/saturate behaviour and carry/borrow between digits. It sits between the board push-buttons and the seven-segment display driver, and replaces the per-button clocked nibble counter.

## Interface
- DIGITS, 4: number of digits and buttons.
- DIGIT_W, 4: bits per digit. RADIX must satisfy RADIX ≤ 2^DIGIT_W.
- RADIX, 16: digit modulus, legal range 2..2^DIGIT_W.
- INIT, 16'hABCD: reset/clear value, DIGITS*DIGIT_W bits. Every digit must be < RADIX.
- DEBOUNCE_CYCLES, 1_000_000: stable cycles required before a level change is accepted. Must be ≥ 1.
- WRAP, 1: 1 = modulo wrap, 0 = saturate at RADIX-1 / 0.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- btn  in  DIGITS  raw asynchronous push-buttons, active-high.
- dir  in  1  0 = increment, 1 = decrement; sampled at apply time.
- carry_en  in  1  1 = propagate carry/borrow to the next more-significant digit. Ignored when WRAP=0.
- clr  in  1  synchronous clear to INIT.
- num  out  DIGITS*DIGIT_W  packed value. btn[i] owns field num[(DIGITS-i)*DIGIT_W-1 -: DIGIT_W], so btn[0] owns the most-significant digit.
- changed  out  1  one-cycle pulse after any update of num (step or clr).
- busy  out  1  at least one press is pending.

## Operation
- Per button: 2-flop synchroniser → debouncer → rising-edge detect.
  - The debounced level toggles once the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample resets the counter.
  - A debounced rising transition sets pending[i].
  - Falling transitions and glitches shorter than DEBOUNCE_CYCLES produce nothing.
- Apply stage, at most one press per cycle:
  - Selects the lowest set index in pending, clears that bit and steps its digit.
  - A new press on an index already pending is absorbed: the bit stays set and the press is not counted twice.
- Step rules, digit d at index i:
  - WRAP=1, up: d==RADIX-1 → 0 with carry; otherwise d+1.
  - WRAP=1, down: d==0 → RADIX-1 with borrow; otherwise d-1.
  - With carry_en=1, carry/borrow ripples combinationally through indices i-1, i-2, … 0 in the same cycle. Carry out of index 0 is discarded, so the whole value wraps.
  - WRAP=0: up saturates at RADIX-1, down saturates at 0, and there is never a carry.
- clr:
  - Loads INIT and clears all pending bits.
  - Has priority over a same-cycle apply; that press is lost.
  - Debouncer state is kept.
- Reset values:
  - num = INIT; changed = 0; busy = 0; pending = 0.
  - Synchroniser and debounced levels = 0; debounce counters = 0.
  - Reset asserted mid-debounce or with presses pending discards them all.

## Timing
- Let e0 be the first clk edge that samples btn[i] high, with btn held stable.
  - sync2 is high after e1.
  - The debounced level rises and pending[i] sets at edge e(D+1), where D = DEBOUNCE_CYCLES.
  - num updates at e(D+2) if no lower index is pending.
  - changed is high during the cycle following e(D+2).
- Queued presses add one cycle per lower-index pending bit ahead of them.
- busy equals |pending, registered.
- Throughput: one digit step per cycle.

## Structure
- Package digit_entry_pkg holds:
  - a function computing the counter width, $clog2(DEBOUNCE_CYCLES+1);
  - the step function for digit, dir, carry_in, WRAP and RADIX, returning next digit plus carry_out.
- Sub-module btn_debounce (one clk, rst_n; sync + counter + rise pulse) is instantiated DIGITS times via generate.
- Top level holds the pending register, priority select, ripple chain, clr and changed.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and the remaining defaults unless noted.
- Reset then btn[3] held high 10 cycles → num goes 16'hABCD → 16'hABCE exactly 6 edges after first sample; changed pulses once.
- btn[0] toggles with 3-cycle high pulses → num unchanged, busy stays 0.
- num = 16'h0FFF, carry_en=1, dir=0, press btn[3] → 16'h1000. From 16'hFFFF → 16'h0000.
- num = 16'h1000, dir=1, carry_en=1, press btn[3] → 16'h0FFF. With carry_en=0 → 16'h100F.
- RADIX=10, WRAP=0, num = 16'h9999, press btn[2] up → unchanged, changed still pulses. From 16'h0000 down → unchanged.
- btn[1] and btn[3] rise on the same edge → busy high 2 cycles; btn[1]'s digit updates one cycle before btn[3]'s. clr asserted on btn[3]'s apply cycle → num = INIT and busy = 0.
